issue_select_arbiter: RTL and testbench

ISSUE_SELECT_ARBITER -- requirements
Module: issue_select_arbiter

---
 rtl/issue_select_arbiter_pkg.sv | 22 ++
 rtl/issue_select_arbiter_encoder.sv | 27 ++
 rtl/issue_select_arbiter.sv | 160 ++++++++++++++++
 tb/tb_issue_select_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/issue_select_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// issue_select_arbiter_pkg
//   Shared issue-stage definitions used by the issue select arbiter:
//     - ISSUE_WIDTH / ISSUE_WIDTH_LOG : global issue-width constants that set
//       the default requester count of the arbiter.
//     - arb_state_e                   : arbiter ownership state.
// -----------------------------------------------------------------------------
package issue_select_arbiter_pkg;

    localparam int ISSUE_WIDTH     = 32;
    localparam int ISSUE_WIDTH_LOG = 5;

    // IDLE   : nothing presented
    // GRANT  : single-beat grant presented
    // LOCKED : multi-beat ownership in progress
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

endpackage : issue_select_arbiter_pkg

// File: rtl/issue_select_arbiter_encoder.sv
// -----------------------------------------------------------------------------
// issue_select_arbiter_encoder
//   One-hot to binary encoder. An all-zero input encodes to index 0.
//
// Ports:
//   onehot_i : ENCODER_WIDTH-bit one-hot vector (at most one bit set)
//   idx_o    : binary index of the set bit
// -----------------------------------------------------------------------------
module issue_select_arbiter_encoder #(
    parameter int ENCODER_WIDTH = 32,
    parameter int IDX_W         = $clog2(ENCODER_WIDTH)
) (
    input  logic [ENCODER_WIDTH-1:0] onehot_i,
    output logic [IDX_W-1:0]         idx_o
);

    // OR-reduction of the indices of the set bits; exact for one-hot input.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < ENCODER_WIDTH; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule : issue_select_arbiter_encoder

// File: rtl/issue_select_arbiter.sv
// -----------------------------------------------------------------------------
// issue_select_arbiter
//   Round-robin issue select arbiter with optional multi-beat locked ownership.
//   A request seen in IDLE is granted on the next cycle. A grant is held
//   stable until accepted (grant_valid_o & grant_ready_i). On an accepted
//   beat the arbiter either enters/continues a locked ownership of the same
//   requester (up to MAX_HOLD beats) or advances the priority pointer past
//   the granted requester and loads the next pick in the same edge.
//
// Ports:
//   clk            : clock, all state on the rising edge
//   reset          : asynchronous active-low reset
//   flush_i        : synchronous cancel of pending grant and lock
//   req_i          : per-requester request
//   lock_i         : per-requester request for multi-beat ownership
//   grant_ready_i  : downstream accepts the presented grant
//   grant_valid_o  : grant presented
//   grant_onehot_o : one-hot granted requester (zero when invalid)
//   grant_idx_o    : binary index of granted requester (zero when invalid)
//   locked_o       : current grant is a locked ownership
// -----------------------------------------------------------------------------
module issue_select_arbiter
    import issue_select_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = ISSUE_WIDTH,
    parameter int NUM_REQ_LOG = ISSUE_WIDTH_LOG,
    parameter int MAX_HOLD    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     lock_i,
    input  logic                   grant_ready_i,
    output logic                   grant_valid_o,
    output logic [NUM_REQ-1:0]     grant_onehot_o,
    output logic [NUM_REQ_LOG-1:0] grant_idx_o,
    output logic                   locked_o
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ_LOG-1:0] ptr_q,   ptr_d;
    logic [NUM_REQ-1:0]     oh_q,    oh_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic                   accept;
    logic                   rel;
    logic [NUM_REQ_LOG-1:0] ptr_adv;

    // Round-robin pick: the low half holds requests at or above ptr, the high
    // half holds all requests. The lowest set bit of the doubled vector is the
    // first request at/after ptr, wrapping to the bottom if none is above it.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0]     req,
        input logic [NUM_REQ_LOG-1:0] ptr
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [2*NUM_REQ-1:0] low;
        dbl = {req, req & ({NUM_REQ{1'b1}} << ptr)};
        low = dbl & (~dbl + (2*NUM_REQ)'(1));
        return low[NUM_REQ-1:0] | low[2*NUM_REQ-1:NUM_REQ];
    endfunction

    issue_select_arbiter_encoder #(
        .ENCODER_WIDTH (NUM_REQ),
        .IDX_W         (NUM_REQ_LOG)
    ) u_encoder (
        .onehot_i (oh_q),
        .idx_o    (grant_idx_o)
    );

    assign accept  = grant_valid_o & grant_ready_i;
    assign ptr_adv = grant_idx_o + NUM_REQ_LOG'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    oh_d    = rr_pick(req_i, ptr_q);
                end
            end
            GRANT: begin
                if (accept) begin
                    // With MAX_HOLD of 1 the first beat already exhausts the
                    // ownership, so a lock request releases immediately.
                    if (lock_i[grant_idx_o] && (MAX_HOLD > 1)) begin
                        state_d = LOCKED;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        rel = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (!lock_i[grant_idx_o] || (cnt_q == CNT_W'(MAX_HOLD - 1))) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                oh_d    = '0;
                cnt_d   = '0;
            end
        endcase

        // Release: advance past the granted requester and load the next pick
        // using the advanced pointer in the same edge (no bubble).
        if (rel) begin
            ptr_d = ptr_adv;
            cnt_d = '0;
            if (|req_i) begin
                state_d = GRANT;
                oh_d    = rr_pick(req_i, ptr_adv);
            end else begin
                state_d = IDLE;
                oh_d    = '0;
            end
        end

        // Flush wins over any simultaneous acceptance; the pointer is kept.
        if (flush_i) begin
            state_d = IDLE;
            ptr_d   = ptr_q;
            oh_d    = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            oh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid_o  = (state_q != IDLE);
    assign grant_onehot_o = oh_q;
    assign locked_o       = (state_q == LOCKED);

endmodule : issue_select_arbiter

// File: tb/tb_issue_select_arbiter.sv
module tb_issue_select_arbiter;

    localparam int N  = 8;
    localparam int NL = 3;

    logic          clk;
    logic          reset;
    logic          flush_i;
    logic [N-1:0]  req_i;
    logic [N-1:0]  lock_i;
    logic          grant_ready_i;
    logic          grant_valid_o;
    logic [N-1:0]  grant_onehot_o;
    logic [NL-1:0] grant_idx_o;
    logic          locked_o;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic         rdy;
        logic         flush;
        logic         ev;
        int           eidx;
        logic         elk;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    issue_select_arbiter #(
        .NUM_REQ     (N),
        .NUM_REQ_LOG (NL),
        .MAX_HOLD    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .req_i          (req_i),
        .lock_i         (lock_i),
        .grant_ready_i  (grant_ready_i),
        .grant_valid_o  (grant_valid_o),
        .grant_onehot_o (grant_onehot_o),
        .grant_idx_o    (grant_idx_o),
        .locked_o       (locked_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic ev, input int eidx, input logic elk);
        logic [NL-1:0] ei;
        logic [N-1:0]  eoh;
        ei  = ev ? NL'(eidx) : '0;
        eoh = ev ? (N'(1) << ei) : '0;
        tests++;
        if (grant_valid_o !== ev || grant_idx_o !== ei || grant_onehot_o !== eoh || locked_o !== elk) begin
            failed++;
            $display("FAIL %s: got v=%0b idx=%0d oh=%b lk=%0b, expected v=%0b idx=%0d oh=%b lk=%0b",
                     name, grant_valid_o, grant_idx_o, grant_onehot_o, locked_o, ev, ei, eoh, elk);
        end
    endtask

    initial begin
        //            req    lock   rdy   flush  ev    idx elk
        // round robin over 0x94, no bubbles: 2,4,7,2,4,7
        vecs[0]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 2, 1'b0};
        vecs[1]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 4, 1'b0};
        vecs[2]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 7, 1'b0};
        vecs[3]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 2, 1'b0};
        vecs[4]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 4, 1'b0};
        vecs[5]  = '{8'h94, 8'h00, 1'b1, 1'b0, 1'b1, 7, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // ptr -> 0
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0};  // no req: stay idle
        // lock held on idx 1: four beats, then idx 3
        vecs[8]  = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b0};
        vecs[9]  = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b1};
        vecs[10] = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b1};
        vecs[11] = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b1};
        vecs[12] = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 3, 1'b0};
        vecs[13] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // ptr -> 4
        // lock dropped: unaccepted drop holds, accepted drop at beat 2 releases
        vecs[14] = '{8'h0A, 8'h02, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[15] = '{8'h0A, 8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b1};
        vecs[16] = '{8'h0A, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1};
        vecs[17] = '{8'h0A, 8'h00, 1'b1, 1'b0, 1'b1, 3, 1'b0};
        vecs[18] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // ptr -> 4
        // flush coincident with acceptance of idx 5 keeps ptr at 4
        vecs[19] = '{8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 5, 1'b0};
        vecs[20] = '{8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[21] = '{8'h21, 8'h00, 1'b0, 1'b0, 1'b1, 5, 1'b0};
        vecs[22] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // ptr -> 6
        // flush in IDLE beats a pending request; wrap from ptr 6 to idx 0
        vecs[23] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[24] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[25] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // ptr -> 1

        reset         = 1'b0;
        flush_i       = 1'b0;
        req_i         = '0;
        lock_i        = '0;
        grant_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 1'b0, 0, 1'b0);
        reset = 1'b1;
        tick();
        check("idle_after_reset", 1'b0, 0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            req_i         = vecs[i].req;
            lock_i        = vecs[i].lock;
            grant_ready_i = vecs[i].rdy;
            flush_i       = vecs[i].flush;
            tick();
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].elk);
        end
        flush_i = 1'b0;

        // Grant held stable under back-pressure while the request drops.
        req_i         = 8'h01;
        lock_i        = '0;
        grant_ready_i = 1'b0;
        tick();
        check("hold_t1", 1'b1, 0, 1'b0);
        req_i = 8'h00;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("hold_t%0d", k), 1'b1, 0, 1'b0);
        end
        grant_ready_i = 1'b1;
        tick();
        check("hold_accepted_idle", 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of a locked ownership (ptr is 1).
        req_i         = 8'h02;
        lock_i        = 8'h02;
        grant_ready_i = 1'b1;
        tick();
        check("pre_lock_grant", 1'b1, 1, 1'b0);
        tick();
        check("pre_lock_locked", 1'b1, 1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", 1'b0, 0, 1'b0);
        @(negedge clk);
        check("async_reset_held", 1'b0, 0, 1'b0);
        reset         = 1'b1;
        req_i         = 8'hFF;
        lock_i        = 8'h00;
        grant_ready_i = 1'b0;
        tick();
        check("post_reset_ptr0", 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_issue_select_arbiter
